// File: rtl/pipeline_mem_stage_pkg.sv
`default_nettype none
// ============================================================================
// pipeline_mem_stage_pkg
// Shared encodings and helpers for the memory pipeline stage.
// Revision: 1.0
// ============================================================================
package pipeline_mem_stage_pkg;

  typedef enum logic [2:0] {
    F3_B  = 3'b000,
    F3_H  = 3'b001,
    F3_W  = 3'b010,
    F3_D  = 3'b011,
    F3_BU = 3'b100,
    F3_HU = 3'b101,
    F3_WU = 3'b110
  } mem_funct3_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_HOLD = 2'd2
  } mem_state_e;

  typedef enum logic [1:0] {
    WB_SEL_ZERO = 2'b00,
    WB_SEL_PC4  = 2'b01,
    WB_SEL_ALU  = 2'b10,
    WB_SEL_MEM  = 2'b11
  } wb_sel_e;

  // Size is carried in funct3[1:0]; funct3[2] only selects zero-extension.
  function automatic logic is_aligned(input logic [2:0] funct3, input logic [2:0] addr_lo);
    logic ok;
    case (funct3[1:0])
      2'b00:   ok = 1'b1;
      2'b01:   ok = ~addr_lo[0];
      2'b10:   ok = (addr_lo[1:0] == 2'b00);
      default: ok = (addr_lo == 3'b000);
    endcase
    return ok;
  endfunction

endpackage
`default_nettype wire

// File: rtl/pipeline_mem_stage_if.sv
`default_nettype none
// ============================================================================
// pipeline_mem_stage_if
// EX-side inputs, data-memory port and MEM/WB outputs of the memory stage.
// Revision: 1.0
// ============================================================================
interface pipeline_mem_stage_if;
  logic        stall;
  logic        valid_EX;
  logic        mem_read_EX;
  logic        mem_write_EX;
  logic        reg_write_EX;
  logic [2:0]  funct3_EX;
  logic [1:0]  rf_wr_sel_EX;
  logic [63:0] alu_result_EX;
  logic [63:0] rs2_data_EX;
  logic [63:0] pc_EX;
  logic [4:0]  rd_EX;

  logic        dmem_req;
  logic        dmem_we;
  logic [63:0] dmem_addr;
  logic [63:0] dmem_wdata;
  logic [7:0]  dmem_wstrb;
  logic [63:0] dmem_rdata;
  logic        dmem_ack;

  logic        mem_stall;
  logic [63:0] alu_result_MEM;
  logic [63:0] mem_data_MEM;
  logic [63:0] pc_MEM;
  logic [4:0]  rd_MEM;
  logic [1:0]  rf_wr_sel_MEM;
  logic        reg_write_MEM;
  logic        misalign_MEM;

  modport slave (
    input  stall, valid_EX, mem_read_EX, mem_write_EX, reg_write_EX, funct3_EX,
           rf_wr_sel_EX, alu_result_EX, rs2_data_EX, pc_EX, rd_EX,
           dmem_rdata, dmem_ack,
    output dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_wstrb,
           mem_stall, alu_result_MEM, mem_data_MEM, pc_MEM, rd_MEM,
           rf_wr_sel_MEM, reg_write_MEM, misalign_MEM
  );

  modport master (
    output stall, valid_EX, mem_read_EX, mem_write_EX, reg_write_EX, funct3_EX,
           rf_wr_sel_EX, alu_result_EX, rs2_data_EX, pc_EX, rd_EX,
           dmem_rdata, dmem_ack,
    input  dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_wstrb,
           mem_stall, alu_result_MEM, mem_data_MEM, pc_MEM, rd_MEM,
           rf_wr_sel_MEM, reg_write_MEM, misalign_MEM
  );
endinterface
`default_nettype wire

// File: rtl/pipeline_mem_stage_formatter.sv
`default_nettype none
// ============================================================================
// mem_lane_formatter
// Combinational load lane extract/extend and store replicate/strobe.
// Revision: 1.0
// ============================================================================
module mem_lane_formatter
  import pipeline_mem_stage_pkg::*;
(
  input  logic [2:0]  i_funct3,
  input  logic [2:0]  i_addr_lo,
  input  logic [63:0] i_ld_rdata,
  input  logic [63:0] i_st_data,
  output logic [63:0] o_ld_data,
  output logic [63:0] o_st_wdata,
  output logic [7:0]  o_st_wstrb
);

  logic [63:0] w_shifted;
  logic [7:0]  w_strb_base;

  always_comb begin
    w_shifted = i_ld_rdata >> {i_addr_lo, 3'b000};
    case (mem_funct3_e'(i_funct3))
      F3_B:    o_ld_data = {{56{w_shifted[7]}},  w_shifted[7:0]};
      F3_H:    o_ld_data = {{48{w_shifted[15]}}, w_shifted[15:0]};
      F3_W:    o_ld_data = {{32{w_shifted[31]}}, w_shifted[31:0]};
      F3_BU:   o_ld_data = {56'd0, w_shifted[7:0]};
      F3_HU:   o_ld_data = {48'd0, w_shifted[15:0]};
      F3_WU:   o_ld_data = {32'd0, w_shifted[31:0]};
      default: o_ld_data = w_shifted;
    endcase
  end

  // Replicating store data means any aligned lane already carries the right bytes.
  always_comb begin
    case (i_funct3[1:0])
      2'b00: begin
        o_st_wdata  = {8{i_st_data[7:0]}};
        w_strb_base = 8'h01;
      end
      2'b01: begin
        o_st_wdata  = {4{i_st_data[15:0]}};
        w_strb_base = 8'h03;
      end
      2'b10: begin
        o_st_wdata  = {2{i_st_data[31:0]}};
        w_strb_base = 8'h0F;
      end
      default: begin
        o_st_wdata  = i_st_data;
        w_strb_base = 8'hFF;
      end
    endcase
    o_st_wstrb = w_strb_base << i_addr_lo;
  end

endmodule
`default_nettype wire

// File: rtl/pipeline_mem_stage.sv
`default_nettype none
// ============================================================================
// pipeline_mem_stage
// MEM pipeline stage: issues data-memory requests and registers results to WB.
// Revision: 1.0
// ============================================================================
module pipeline_mem_stage
  import pipeline_mem_stage_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  pipeline_mem_stage_if.slave  bus
);

  mem_state_e  state_q, state_d;
  logic        dmem_req_q, dmem_req_d;
  logic        dmem_we_q, dmem_we_d;
  logic [63:0] dmem_addr_q, dmem_addr_d;
  logic [63:0] dmem_wdata_q, dmem_wdata_d;
  logic [7:0]  dmem_wstrb_q, dmem_wstrb_d;
  logic [63:0] ld_buf_q, ld_buf_d;
  logic [63:0] alu_result_q, alu_result_d;
  logic [63:0] mem_data_q, mem_data_d;
  logic [63:0] pc_q, pc_d;
  logic [4:0]  rd_q, rd_d;
  logic [1:0]  rf_wr_sel_q, rf_wr_sel_d;
  logic        reg_write_q, reg_write_d;
  logic        misalign_q, misalign_d;

  logic        w_mem_access;
  logic        w_mem_op;
  logic        w_is_load;
  logic        w_mem_stall;
  logic [63:0] w_ld_fmt;
  logic [63:0] w_ld_data;
  logic [63:0] w_st_wdata;
  logic [7:0]  w_st_wstrb;
  logic        w_cap_en;
  logic        w_cap_rw;
  logic        w_cap_mis;
  logic [4:0]  w_cap_rd;
  logic [63:0] w_cap_data;

  assign w_mem_access = bus.valid_EX & (bus.mem_read_EX | bus.mem_write_EX);
  assign w_mem_op     = w_mem_access & is_aligned(bus.funct3_EX, bus.alu_result_EX[2:0]);
  assign w_is_load    = bus.mem_read_EX & ~bus.mem_write_EX;
  assign w_ld_data    = w_is_load ? w_ld_fmt : 64'd0;

  mem_lane_formatter u_fmt (
    .i_funct3   (bus.funct3_EX),
    .i_addr_lo  (bus.alu_result_EX[2:0]),
    .i_ld_rdata (bus.dmem_rdata),
    .i_st_data  (bus.rs2_data_EX),
    .o_ld_data  (w_ld_fmt),
    .o_st_wdata (w_st_wdata),
    .o_st_wstrb (w_st_wstrb)
  );

  always_comb begin
    case (state_q)
      ST_IDLE: w_mem_stall = w_mem_op | bus.stall;
      ST_WAIT: w_mem_stall = ~bus.dmem_ack | bus.stall;
      ST_HOLD: w_mem_stall = bus.stall;
      default: w_mem_stall = 1'b0;
    endcase
  end

  always_comb begin
    state_d      = state_q;
    dmem_req_d   = dmem_req_q;
    dmem_we_d    = dmem_we_q;
    dmem_addr_d  = dmem_addr_q;
    dmem_wdata_d = dmem_wdata_q;
    dmem_wstrb_d = dmem_wstrb_q;
    ld_buf_d     = ld_buf_q;
    w_cap_en     = 1'b0;
    w_cap_rw     = bus.valid_EX & bus.reg_write_EX;
    w_cap_rd     = bus.valid_EX ? bus.rd_EX : 5'd0;
    w_cap_mis    = 1'b0;
    w_cap_data   = 64'd0;

    // While an access is in flight the op is still parked in EX, so an
    // unstalled WB is fed bubbles rather than a duplicate of the op.
    case (state_q)
      ST_IDLE: begin
        if (w_mem_op) begin
          state_d      = ST_WAIT;
          dmem_req_d   = 1'b1;
          dmem_we_d    = bus.mem_write_EX;
          dmem_addr_d  = bus.alu_result_EX;
          dmem_wdata_d = w_st_wdata;
          dmem_wstrb_d = bus.mem_write_EX ? w_st_wstrb : 8'h00;
          w_cap_en     = ~bus.stall;
          w_cap_rw     = 1'b0;
          w_cap_rd     = 5'd0;
        end else if (!bus.stall) begin
          w_cap_en = 1'b1;
          if (w_mem_access) begin
            w_cap_rw  = 1'b0;
            w_cap_mis = 1'b1;
          end
        end
      end
      ST_WAIT: begin
        if (bus.dmem_ack) begin
          dmem_req_d   = 1'b0;
          dmem_we_d    = 1'b0;
          dmem_wstrb_d = 8'h00;
          if (bus.stall) begin
            ld_buf_d = w_ld_data;
            state_d  = ST_HOLD;
          end else begin
            w_cap_en   = 1'b1;
            w_cap_data = w_ld_data;
            state_d    = ST_IDLE;
          end
        end else if (!bus.stall) begin
          w_cap_en = 1'b1;
          w_cap_rw = 1'b0;
          w_cap_rd = 5'd0;
        end
      end
      ST_HOLD: begin
        if (!bus.stall) begin
          w_cap_en   = 1'b1;
          w_cap_data = ld_buf_q;
          state_d    = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    alu_result_d = alu_result_q;
    mem_data_d   = mem_data_q;
    pc_d         = pc_q;
    rd_d         = rd_q;
    rf_wr_sel_d  = rf_wr_sel_q;
    reg_write_d  = reg_write_q;
    misalign_d   = misalign_q;
    if (w_cap_en) begin
      alu_result_d = bus.alu_result_EX;
      mem_data_d   = w_cap_data;
      pc_d         = bus.pc_EX;
      rd_d         = w_cap_rd;
      rf_wr_sel_d  = bus.rf_wr_sel_EX;
      reg_write_d  = w_cap_rw;
      misalign_d   = w_cap_mis;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      dmem_req_q   <= 1'b0;
      dmem_we_q    <= 1'b0;
      dmem_addr_q  <= 64'd0;
      dmem_wdata_q <= 64'd0;
      dmem_wstrb_q <= 8'h00;
      ld_buf_q     <= 64'd0;
      alu_result_q <= 64'd0;
      mem_data_q   <= 64'd0;
      pc_q         <= 64'd0;
      rd_q         <= 5'd0;
      rf_wr_sel_q  <= 2'b00;
      reg_write_q  <= 1'b0;
      misalign_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      dmem_req_q   <= dmem_req_d;
      dmem_we_q    <= dmem_we_d;
      dmem_addr_q  <= dmem_addr_d;
      dmem_wdata_q <= dmem_wdata_d;
      dmem_wstrb_q <= dmem_wstrb_d;
      ld_buf_q     <= ld_buf_d;
      alu_result_q <= alu_result_d;
      mem_data_q   <= mem_data_d;
      pc_q         <= pc_d;
      rd_q         <= rd_d;
      rf_wr_sel_q  <= rf_wr_sel_d;
      reg_write_q  <= reg_write_d;
      misalign_q   <= misalign_d;
    end
  end

  assign bus.mem_stall      = w_mem_stall;
  assign bus.dmem_req       = dmem_req_q;
  assign bus.dmem_we        = dmem_we_q;
  assign bus.dmem_addr      = dmem_addr_q;
  assign bus.dmem_wdata     = dmem_wdata_q;
  assign bus.dmem_wstrb     = dmem_wstrb_q;
  assign bus.alu_result_MEM = alu_result_q;
  assign bus.mem_data_MEM   = mem_data_q;
  assign bus.pc_MEM         = pc_q;
  assign bus.rd_MEM         = rd_q;
  assign bus.rf_wr_sel_MEM  = rf_wr_sel_q;
  assign bus.reg_write_MEM  = reg_write_q;
  assign bus.misalign_MEM   = misalign_q;

endmodule
`default_nettype wire

// File: tb/tb_pipeline_mem_stage.sv
`default_nettype none
// ============================================================================
// tb_pipeline_mem_stage
// Directed and randomized bench for the memory stage against a reference model.
// Revision: 1.0
// ============================================================================
module tb_pipeline_mem_stage;
  import pipeline_mem_stage_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  pipeline_mem_stage_if bus();

  pipeline_mem_stage dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;
  bit checking = 1'b0;

  // Reference model: an outstanding-request flag, a buffered-result flag and
  // the values WB and memory should currently be seeing.
  bit          pend = 1'b0, held = 1'b0, ex_adv = 1'b1;
  logic [63:0] hdata = '0;
  bit          m_req = 1'b0, m_we = 1'b0, m_rw = 1'b0, m_mis = 1'b0;
  logic [63:0] m_addr = '0, m_wdata = '0, m_alu = '0, m_md = '0, m_pc = '0;
  logic [7:0]  m_wstrb = '0;
  logic [4:0]  m_rd = '0;
  logic [1:0]  m_sel = '0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int nbytes(input logic [2:0] f3);
    return 1 << (f3 % 4);
  endfunction

  function automatic logic [63:0] ld_fmt(input logic [2:0] f3, input logic [63:0] addr,
                                         input logic [63:0] rdata);
    int n;
    int lane;
    logic [63:0] v, lim;
    n    = nbytes(f3);
    lane = int'(addr % 64'd8);
    v    = rdata >> (lane * 8);
    if (n < 8) begin
      lim = 64'd1 << (n * 8);
      v   = v % lim;
      if (f3 < 3'd4 && v >= (lim >> 1)) v = v - lim;
    end
    return v;
  endfunction

  function automatic logic [63:0] st_rep(input logic [2:0] f3, input logic [63:0] d);
    int n;
    logic [63:0] piece, r;
    n     = nbytes(f3);
    piece = (n == 8) ? d : d % (64'd1 << (n * 8));
    r     = '0;
    for (int k = 0; k < 8; k += n) r = r | (piece << (k * 8));
    return r;
  endfunction

  function automatic logic [7:0] st_strb(input logic [2:0] f3, input logic [63:0] addr);
    int s;
    s = ((1 << nbytes(f3)) - 1) << int'(addr % 64'd8);
    return s[7:0];
  endfunction

  function automatic bit mem_acc();
    return bus.valid_EX && (bus.mem_read_EX || bus.mem_write_EX);
  endfunction

  function automatic bit mem_ok();
    return mem_acc() && ((bus.alu_result_EX % 64'(nbytes(bus.funct3_EX))) == 64'd0);
  endfunction

  function automatic bit model_stall();
    if (held) return bus.stall;
    if (pend) return !bus.dmem_ack || bus.stall;
    return mem_ok() || bus.stall;
  endfunction

  task automatic capture(input bit rw, input logic [4:0] rd, input bit mis, input logic [63:0] d);
    m_alu = bus.alu_result_EX;
    m_pc  = bus.pc_EX;
    m_sel = bus.rf_wr_sel_EX;
    m_rw  = rw;
    m_rd  = rd;
    m_mis = mis;
    m_md  = d;
  endtask

  task automatic model_step();
    bit ms;
    logic [63:0] d;
    ms     = model_stall();
    ex_adv = reset || !ms;
    if (reset) begin
      pend = 0; held = 0; hdata = '0;
      m_req = 0; m_we = 0; m_addr = '0; m_wdata = '0; m_wstrb = '0;
      m_alu = '0; m_md = '0; m_pc = '0; m_rd = '0; m_sel = '0; m_rw = 0; m_mis = 0;
      return;
    end
    if (held) begin
      if (!bus.stall) begin
        capture(bus.reg_write_EX, bus.rd_EX, 0, hdata);
        held = 0;
      end
    end else if (pend) begin
      if (bus.dmem_ack) begin
        d = (bus.mem_read_EX && !bus.mem_write_EX) ?
            ld_fmt(bus.funct3_EX, bus.alu_result_EX, bus.dmem_rdata) : 64'd0;
        pend = 0; m_req = 0; m_we = 0; m_wstrb = '0;
        if (bus.stall) begin
          held = 1; hdata = d;
        end else begin
          capture(bus.reg_write_EX, bus.rd_EX, 0, d);
        end
      end else if (!bus.stall) begin
        capture(0, 5'd0, 0, 64'd0);
      end
    end else if (mem_ok()) begin
      pend    = 1;
      m_req   = 1;
      m_addr  = bus.alu_result_EX;
      m_we    = bus.mem_write_EX;
      m_wdata = st_rep(bus.funct3_EX, bus.rs2_data_EX);
      m_wstrb = bus.mem_write_EX ? st_strb(bus.funct3_EX, bus.alu_result_EX) : 8'h00;
      if (!bus.stall) capture(0, 5'd0, 0, 64'd0);
    end else if (!bus.stall) begin
      if (mem_acc())          capture(0, bus.rd_EX, 1, 64'd0);
      else if (bus.valid_EX)  capture(bus.reg_write_EX, bus.rd_EX, 0, 64'd0);
      else                    capture(0, 5'd0, 0, 64'd0);
    end
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  initial forever begin
    @(negedge clk);
    if (checking) begin
      chk("mem_stall", bus.mem_stall, model_stall());
      chk("dmem_req", bus.dmem_req, m_req);
      if (m_req) begin
        chk("dmem_addr", bus.dmem_addr, m_addr);
        chk("dmem_we", bus.dmem_we, m_we);
        chk("dmem_wstrb", bus.dmem_wstrb, m_wstrb);
        if (m_we) chk("dmem_wdata", bus.dmem_wdata, m_wdata);
      end
      chk("alu_result_MEM", bus.alu_result_MEM, m_alu);
      chk("mem_data_MEM", bus.mem_data_MEM, m_md);
      chk("pc_MEM", bus.pc_MEM, m_pc);
      chk("rd_MEM", bus.rd_MEM, m_rd);
      chk("rf_wr_sel_MEM", bus.rf_wr_sel_MEM, m_sel);
      chk("reg_write_MEM", bus.reg_write_MEM, m_rw);
      chk("misalign_MEM", bus.misalign_MEM, m_mis);
    end
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog expired");
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ex(input bit v, input bit rdv, input bit wrv, input bit rw,
                        input logic [2:0] f3, input logic [63:0] alu, input logic [63:0] rs2,
                        input logic [63:0] pc, input logic [4:0] rd, input logic [1:0] sel);
    bus.valid_EX      = v;
    bus.mem_read_EX   = rdv;
    bus.mem_write_EX  = wrv;
    bus.reg_write_EX  = rw;
    bus.funct3_EX     = f3;
    bus.alu_result_EX = alu;
    bus.rs2_data_EX   = rs2;
    bus.pc_EX         = pc;
    bus.rd_EX         = rd;
    bus.rf_wr_sel_EX  = sel;
  endtask

  task automatic bubble();
    set_ex(0, 0, 0, 0, 3'd0, 64'd0, 64'd0, 64'd0, 5'd0, 2'd0);
  endtask

  task automatic random_ex();
    int kind;
    logic [63:0] a;
    kind = $urandom_range(0, 9);
    a    = {$urandom, $urandom};
    if ($urandom_range(0, 1) == 1) a[2:0] = 3'd0;
    if (kind == 0)
      set_ex(0, 0, 0, 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), a,
             {$urandom, $urandom}, {$urandom, $urandom}, 5'($urandom), 2'($urandom));
    else if (kind <= 4)
      set_ex(1, 0, 0, 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), a,
             {$urandom, $urandom}, {$urandom, $urandom}, 5'($urandom), 2'($urandom));
    else if (kind <= 7)
      set_ex(1, 1, 0, 1'($urandom_range(0, 1)), 3'($urandom_range(0, 6)), a,
             {$urandom, $urandom}, {$urandom, $urandom}, 5'($urandom), 2'($urandom));
    else
      set_ex(1, 0, 1, 0, 3'($urandom_range(0, 3)), a,
             {$urandom, $urandom}, {$urandom, $urandom}, 5'($urandom), 2'($urandom));
  endtask

  initial begin
    int n_st;
    logic [63:0] wd;
    bus.stall      = 1'b0;
    bus.dmem_ack   = 1'b0;
    bus.dmem_rdata = '0;
    bubble();

    cyc();
    checking = 1'b1;
    cyc();
    @(negedge clk);
    chk("rst_dmem_req", bus.dmem_req, 0);
    chk("rst_alu", bus.alu_result_MEM, 0);
    chk("rst_rd", bus.rd_MEM, 0);

    // Plain ALU op passes straight through.
    cyc();
    reset = 1'b0;
    set_ex(1, 0, 0, 1, 3'd0, 64'h42, 64'd0, 64'h100, 5'd5, 2'b10);
    @(negedge clk);
    chk("alu_op_stall", bus.mem_stall, 0);
    cyc();
    bubble();
    @(negedge clk);
    chk("alu_op_rd", bus.rd_MEM, 5);
    chk("alu_op_alu", bus.alu_result_MEM, 64'h42);
    chk("alu_op_stall2", bus.mem_stall, 0);

    // LB lane 3, ack after two waiting cycles.
    cyc();
    set_ex(1, 1, 0, 1, 3'b000, 64'h1003, 64'd0, 64'h200, 5'd7, 2'b11);
    n_st = 0;
    @(negedge clk);
    if (bus.mem_stall) n_st++;
    cyc();
    @(negedge clk);
    chk("lb_req", bus.dmem_req, 1);
    chk("lb_addr", bus.dmem_addr, 64'h1003);
    if (bus.mem_stall) n_st++;
    cyc();
    @(negedge clk);
    if (bus.mem_stall) n_st++;
    cyc();
    bus.dmem_ack   = 1'b1;
    bus.dmem_rdata = 64'h00000000_80FF0000;
    @(negedge clk);
    if (bus.mem_stall) n_st++;
    chk("lb_stall_cycles", 64'(n_st), 3);
    cyc();
    bus.dmem_ack = 1'b0;
    bubble();
    @(negedge clk);
    chk("lb_data", bus.mem_data_MEM, 64'hFFFFFFFF_FFFFFF80);
    chk("lb_rd", bus.rd_MEM, 7);
    chk("lb_req_drop", bus.dmem_req, 0);

    // SH in the top half-word.
    cyc();
    set_ex(1, 0, 1, 0, 3'b001, 64'h2006, 64'h1234, 64'h300, 5'd0, 2'b00);
    @(negedge clk);
    chk("sh_stall", bus.mem_stall, 1);
    cyc();
    @(negedge clk);
    wd = bus.dmem_wdata;
    chk("sh_wstrb", bus.dmem_wstrb, 8'hC0);
    chk("sh_we", bus.dmem_we, 1);
    chk("sh_wdata_hi", wd[63:48], 16'h1234);
    cyc();
    bus.dmem_ack = 1'b1;
    cyc();
    bus.dmem_ack = 1'b0;
    bubble();
    @(negedge clk);
    chk("sh_rw", bus.reg_write_MEM, 0);
    chk("sh_req", bus.dmem_req, 0);

    // Misaligned LW never reaches memory.
    cyc();
    set_ex(1, 1, 0, 1, 3'b010, 64'h3002, 64'd0, 64'h400, 5'd9, 2'b11);
    @(negedge clk);
    chk("lw_mis_stall", bus.mem_stall, 0);
    cyc();
    bubble();
    @(negedge clk);
    chk("lw_mis_req", bus.dmem_req, 0);
    chk("lw_mis_flag", bus.misalign_MEM, 1);
    chk("lw_mis_rw", bus.reg_write_MEM, 0);

    // LD whose ack lands under a three-cycle WB stall.
    cyc();
    set_ex(1, 1, 0, 1, 3'b011, 64'h4008, 64'd0, 64'h500, 5'd11, 2'b11);
    cyc();
    bus.stall      = 1'b1;
    bus.dmem_ack   = 1'b1;
    bus.dmem_rdata = 64'h01234567_89ABCDEF;
    @(negedge clk);
    chk("ld_ack_stall", bus.mem_stall, 1);
    cyc();
    bus.dmem_ack = 1'b0;
    @(negedge clk);
    chk("ld_hold_data", bus.mem_data_MEM, 0);
    chk("ld_hold_stall", bus.mem_stall, 1);
    cyc();
    @(negedge clk);
    chk("ld_hold_data2", bus.mem_data_MEM, 0);
    chk("ld_hold_rd", bus.rd_MEM, 0);
    cyc();
    bus.stall = 1'b0;
    @(negedge clk);
    chk("ld_release_stall", bus.mem_stall, 0);
    cyc();
    bubble();
    @(negedge clk);
    chk("ld_data", bus.mem_data_MEM, 64'h01234567_89ABCDEF);
    chk("ld_rd", bus.rd_MEM, 11);

    // Reset while waiting, then a late ack.
    cyc();
    set_ex(1, 1, 0, 1, 3'b010, 64'h5000, 64'd0, 64'h600, 5'd12, 2'b11);
    cyc();
    @(negedge clk);
    chk("rst_wait_req", bus.dmem_req, 1);
    cyc();
    reset = 1'b1;
    cyc();
    reset          = 1'b0;
    bus.dmem_ack   = 1'b1;
    bus.dmem_rdata = 64'hDEAD_BEEF_CAFE_F00D;
    bubble();
    @(negedge clk);
    chk("rst_req_cleared", bus.dmem_req, 0);
    chk("rst_rd_cleared", bus.rd_MEM, 0);
    cyc();
    bus.dmem_ack = 1'b0;
    @(negedge clk);
    chk("late_ack_req", bus.dmem_req, 0);
    chk("late_ack_data", bus.mem_data_MEM, 0);
    chk("late_ack_alu", bus.alu_result_MEM, 0);
    chk("late_ack_idle", bus.mem_stall, 0);

    // Randomized traffic; EX only advances on cycles the model says it may.
    for (int i = 0; i < 3000; i++) begin
      cyc();
      reset          = ($urandom_range(0, 299) == 0);
      bus.stall      = ($urandom_range(0, 2) == 0);
      bus.dmem_ack   = pend ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 9) == 0);
      bus.dmem_rdata = {$urandom, $urandom};
      if (ex_adv) random_ex();
    end
    cyc();
    @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
